// File: rtl/imm_enc_pkg.sv
// rtl/imm_enc_pkg.sv - widths, output kinds and FSM states shared by the immediate encoder.
package imm_enc_pkg;

  localparam int WORD_W = 16;
  localparam int IMM_W  = 12;

  typedef enum logic [1:0] {
    KIND_SHORT = 2'd0,
    KIND_UPPER = 2'd1,
    KIND_LOWER = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_UPPER = 2'd2,
    ST_LOWER = 2'd3
  } state_e;

endpackage

// File: rtl/imm_splitter.sv
// rtl/imm_splitter.sv - combinational fit test and hi/lo split of a constant.
module imm_splitter #(
  parameter int WORD_W = 16,
  parameter int IMM_W  = 12
) (
  input  logic [WORD_W-1:0]       i_const,
  output logic                    o_fits,
  output logic [WORD_W-IMM_W-1:0] o_hi,
  output logic [IMM_W-1:0]        o_lo
);

  localparam int HI_W = WORD_W - IMM_W;

  logic [HI_W:0] w_top;

  // Fits when everything above the immediate's sign bit repeats that sign bit.
  assign w_top  = i_const[WORD_W-1:IMM_W-1];
  assign o_fits = (&w_top) | ~(|w_top);
  assign o_lo   = i_const[IMM_W-1:0];
  // The decoder sign-extends lo, so a set lo sign bit borrows one from hi.
  assign o_hi   = i_const[WORD_W-1:IMM_W] + HI_W'(i_const[IMM_W-1]);

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - encodes a constant into SHORT or UPPER/LOWER immediate words.
// Optional SHORT encoding is enabled by defining IMM_ENC_SHORT_EN.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int WORD_W = imm_enc_pkg::WORD_W,
  parameter int IMM_W  = imm_enc_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_kind,
  output logic              out_last,
  output logic [15:0]       word_count
);

  localparam int HI_W = WORD_W - IMM_W;

  state_e            r_state;
  state_e            w_next;
  logic [WORD_W-1:0] r_const;
  logic [15:0]       r_word_count;
  logic              w_unused_fits;
  logic [HI_W-1:0]   w_hi;
  logic [IMM_W-1:0]  w_lo;
  logic              w_in_acc;
  logic              w_out_acc;

  imm_splitter #(
    .WORD_W (WORD_W),
    .IMM_W  (IMM_W)
  ) u_splitter (
    .i_const (r_const),
    .o_fits  (w_unused_fits),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

`ifdef IMM_ENC_SHORT_EN
  logic [HI_W:0] w_in_top;
  logic          w_in_fits;
  assign w_in_top  = in_data[WORD_W-1:IMM_W-1];
  assign w_in_fits = (&w_in_top) | ~(|w_in_top);
`endif

  assign w_in_acc   = in_valid && in_ready;
  assign w_out_acc  = out_valid && out_ready;
  assign word_count = r_word_count;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_imm   = '0;
    out_kind  = KIND_SHORT;
    out_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (w_in_acc) begin
`ifdef IMM_ENC_SHORT_EN
          w_next = w_in_fits ? ST_SHORT : ST_UPPER;
`else
          w_next = ST_UPPER;
`endif
        end
      end
`ifdef IMM_ENC_SHORT_EN
      ST_SHORT: begin
        out_valid = 1'b1;
        out_imm   = w_lo;
        out_kind  = KIND_SHORT;
        out_last  = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
`endif
      ST_UPPER: begin
        out_valid = 1'b1;
        out_imm   = {{(IMM_W-HI_W){1'b0}}, w_hi};
        out_kind  = KIND_UPPER;
        if (out_ready) w_next = ST_LOWER;
      end
      ST_LOWER: begin
        out_valid = 1'b1;
        out_imm   = w_lo;
        out_kind  = KIND_LOWER;
        out_last  = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_const      <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_in_acc)  r_const      <= in_data;
      if (w_out_acc) r_word_count <= r_word_count + 16'd1;
    end
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Encodes a 16-bit constant into one or two 12-bit immediate words for the stack processor's instruction stream. It is the inverse of the decode-stage 12→16 sign extender: a constant that fits in a signed 12-bit field is emitted as a single SHORT word, and any other constant is emitted as an UPPER/LOWER pair that the decoder reassembles. The block sits between the assembler-side constant source and the instruction packer, with valid/ready handshakes on both sides.

## Interface
- `WORD_W`, default 16: constant width.
- `IMM_W`, default 12: immediate field width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a constant.
- `in_data` input WORD_W: constant to encode.
- `out_valid` output 1: `out_imm` and `out_kind` are valid.
- `out_ready` input 1: the consumer accepts the current word.
- `out_imm` output IMM_W: immediate field.
- `out_kind` output 2: `SHORT`=0, `UPPER`=1, `LOWER`=2.
- `out_last` output 1: last word of the current constant.
- `word_count` output 16: number of output words accepted; wraps modulo 2^16.

## Operation
- **Fit test:** the constant fits when `in_data[15:11]` is all zeros or all ones, i.e. the value is in [-2048, 2047].
- **Split:**
  - `lo = in_data[11:0]`.
  - `hi = (in_data[15:12] + in_data[11]) mod 16`.
  - UPPER word is `{8'b0, hi}`; LOWER word is `lo`.
  - Decoder identity: `(hi<<12) + sext(lo)` mod 2^16 equals `in_data`.
- **FSM states:**
  - IDLE: `in_ready`=1.
    - Fitting constant accepted → go to SHORT.
    - Non-fitting constant accepted → go to UPPER.
  - SHORT: presents `out_imm = in_data[11:0]` with `out_last`=1. On accept → go to IDLE.
  - UPPER: presents the UPPER word with `out_last`=0. On accept → go to LOWER.
  - LOWER: presents the LOWER word with `out_last`=1. On accept → go to IDLE.
- **Handshakes:**
  - `in_ready` is 1 only in IDLE, and is never combinationally dependent on `out_ready`.
  - "Accept" on either side means valid && ready on a rising edge.
  - `out_valid` is 1 in SHORT, UPPER and LOWER.
  - Output fields are held stable while `out_valid` && !`out_ready`.
- **Registers:** the accepted constant is registered; `out_imm`, `out_kind` and `out_last` are derived from the state and the registered constant.
- **Counter:** `word_count` increments by 1 on each output accept. 0xFFFF wraps to 0x0000.
- **Reset values:** IDLE; `in_ready`=1 (high while `rst_n` is high and state is IDLE); `out_valid`=0; `out_imm`=0; `out_kind`=SHORT; `out_last`=0; `word_count`=0; registered constant 0.
- **Reset mid-operation:** deasserting `rst_n` in any state aborts the constant immediately, with no partial word emitted afterwards. The register values are as listed above.

## Timing
- **Latency:** a constant accepted at edge N drives its first word valid after edge N (one-cycle latency).
- **Throughput:** with `out_ready` held high, a SHORT constant takes 2 cycles per constant (IDLE + SHORT) and a pair takes 3 cycles.
- **No overlap:** no new input is accepted until the `out_last` word is accepted, so there is never a simultaneous input accept and output accept.
- **Backpressure:** `out_ready` low stalls indefinitely with the output held; `in_ready` stays 0 during the stall.
- **Idle input:** `in_valid` held high in IDLE is accepted on the next edge. `in_data` is ignored when `in_valid`=0.

## Configuration
- `IMM_ENC_SHORT_EN` defined: SHORT encoding is used for fitting constants, as described above.
- Not defined: every constant is emitted as an UPPER/LOWER pair. The SHORT state is not generated, and `out_kind` never equals SHORT except as its reset value. The split arithmetic is unchanged, e.g. 0x0005 emits UPPER 0x000, then LOWER 0x005.

## Structure
- **Package `imm_enc_pkg`:** `WORD_W`, `IMM_W`, the `out_kind` encodings (`KIND_SHORT`, `KIND_UPPER`, `KIND_LOWER`), and the FSM state encodings.
- **Sub-module `imm_splitter`:** purely combinational.
  - Inputs: the 16-bit constant.
  - Outputs: the `fits` flag, `hi` and `lo`.
  - It is instantiated once, on the registered constant; it is also reusable by the bench as a reference model.

## Test plan
- Input 0x07FF, `out_ready`=1 → one word: SHORT, 0x7FF, `out_last`=1; `word_count`=1. Input 0xF800 → SHORT, 0x800.
- Input 0x0800 → UPPER 0x001, then LOWER 0x800 (`out_last` only on LOWER). Input 0x8800 → UPPER 0x009, then LOWER 0x800.
- Input 0xF7FF → UPPER 0x00F, then LOWER 0x7FF. Input 0x1234 → UPPER 0x001, then LOWER 0x234. Sweep all 65536 inputs; the reconstruction `(hi<<12)+sext(lo)` must equal the input every time.
- Hold `out_ready`=0 for 5 cycles during UPPER of 0x1234 → UPPER 0x001 held stable and `in_ready`=0 throughout; releasing yields LOWER 0x234 on the next cycle.
- Pull `rst_n` low during LOWER → immediately `out_valid`=0 and `word_count`=0; after release, `in_ready`=1 and no LOWER word appears.
- Preload `word_count` to 0xFFFF via 65535 accepts, then one more accept → `word_count` reads 0x0000. Build without `IMM_ENC_SHORT_EN`, input 0x0005 → UPPER 0x000, then LOWER 0x005.
